// File: rtl/pulp_clock_div_n.sv
// pulp_clock_div_n: glitch-free programmable integer clock divider with handshaked ratio updates.
// Define PULP_CLK_DIV_ODD_DUTY_EN for 50% duty cycle on odd ratios (adds a negedge correction flop).
module pulp_clock_div_n #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 clk_o,
    output logic [DIV_WIDTH-1:0] div_o
);

    localparam logic [0:0]           ST_IDLE = 1'b0;
    localparam logic [0:0]           ST_RUN  = 1'b1;
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    logic [0:0]           state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] pend_div_q;
    logic                 pending_q;
    logic [DIV_WIDTH-1:0] hi_len;
    logic [DIV_WIDTH-1:0] div_acc;
    logic                 running;
    logic                 boundary;
    logic                 handshake;
    logic                 hi_next;

    // Number of posedge-evaluated high cycles per period.
    always_comb begin
        hi_len = {1'b0, div_q[DIV_WIDTH-1:1]};
`ifdef PULP_CLK_DIV_ODD_DUTY_EN
        hi_len = hi_len + {{(DIV_WIDTH-1){1'b0}}, div_q[0]};
`endif
    end

    assign running   = (state_q == ST_RUN);
    assign boundary  = running && (cnt_q == (div_q - ONE));
    assign handshake = div_valid_i && !pending_q;
    assign hi_next   = running && (cnt_q < hi_len);
    assign div_acc   = (div_i < DIV_MIN) ? DIV_MIN : div_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_WIDTH'(RESET_DIV);
            pend_div_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            if (handshake) begin
                pending_q  <= 1'b1;
                pend_div_q <= div_acc;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (pending_q) begin
                        div_q     <= pend_div_q;
                        pending_q <= 1'b0;
                    end
                    if (en_i) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    // A handshake in this cycle only sets pending; the old flag decides application.
                    if (boundary) begin
                        cnt_q <= '0;
                        if (pending_q) begin
                            div_q     <= pend_div_q;
                            pending_q <= 1'b0;
                        end
                        if (!en_i) begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
            endcase
        end
    end

`ifdef PULP_CLK_DIV_ODD_DUTY_EN
    logic pos_q;
    logic neg_q;
    logic half_q;

    // pos_q is pre-compensated by neg_q so the XOR shows hi_next; a negedge toggle of neg_q cuts odd high phases by half a cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos_q  <= 1'b0;
            half_q <= 1'b0;
        end else begin
            pos_q  <= hi_next ^ neg_q;
            half_q <= running && div_q[0] && (cnt_q == (hi_len - ONE));
        end
    end

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_q ^ half_q;
        end
    end

    assign clk_o = pos_q ^ neg_q;
`else
    logic clk_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_q <= 1'b0;
        end else begin
            clk_q <= hi_next;
        end
    end

    assign clk_o = clk_q;
`endif

    assign div_ready_o = !pending_q;
    assign div_o       = div_q;

endmodule
